// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS32 pipeline control blocks: register index
// defaults, the zero-register index, stall FSM states and operand slice numbers.
package mips_pipe_pkg;

  localparam int REG_BITS_DEF = 5;
  localparam int XZR_IDX      = 0;
  localparam int DCNT_BITS    = 4;

  localparam int SRC_A = 0;
  localparam int SRC_B = 1;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority match: picks the nearest producer stage that
// writes the requested register, never forwarding the zero register.
module fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int REG_BITS   = REG_BITS_DEF,
  parameter int NUM_STAGES = 2
) (
  input  logic [NUM_STAGES-1:0]          wr_en_stg,
  input  logic [NUM_STAGES*REG_BITS-1:0] wr_reg_stg,
  input  logic [REG_BITS-1:0]            src_reg,
  output logic [NUM_STAGES-1:0]          sel
);

  // Ascending scan so a higher (nearer) stage overwrites any farther match.
  always_comb begin
    sel = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (wr_en_stg[s] &&
          (wr_reg_stg[s*REG_BITS +: REG_BITS] != REG_BITS'(XZR_IDX)) &&
          (wr_reg_stg[s*REG_BITS +: REG_BITS] == src_reg)) begin
        sel    = '0;
        sel[s] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: registered one-hot forward selects per
// operand, a multi-cycle load-use stall FSM and a saturating stall counter.
module fwd_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_BITS          = REG_BITS_DEF,
  parameter int NUM_SRC           = 2,
  parameter int NUM_STAGES        = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_BITS          = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_STAGES-1:0]          wr_en_stg,
  input  logic [NUM_STAGES*REG_BITS-1:0] wr_reg_stg,
  input  logic [NUM_SRC*REG_BITS-1:0]    src_reg_f3,
  input  logic [NUM_SRC*REG_BITS-1:0]    src_reg_f2,
  input  logic [NUM_SRC-1:0]             src_used_f2,
  input  logic                           mem_read_f3,
  input  logic [REG_BITS-1:0]            wr_reg_f3,
  output logic [NUM_SRC*NUM_STAGES-1:0]  fw_sel,
  output logic                           stall,
  output logic [CNT_BITS-1:0]            stall_cycles
);

  logic [NUM_SRC*NUM_STAGES-1:0] fw_next;
  logic                          src_hit;
  logic                          hit;
  stall_state_t                  state, state_next;
  logic [DCNT_BITS-1:0]          dcnt, dcnt_next;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_sel
    fwd_select #(
      .REG_BITS  (REG_BITS),
      .NUM_STAGES(NUM_STAGES)
    ) u_fwd_select (
      .wr_en_stg (wr_en_stg),
      .wr_reg_stg(wr_reg_stg),
      .src_reg   (src_reg_f3[k*REG_BITS +: REG_BITS]),
      .sel       (fw_next[k*NUM_STAGES +: NUM_STAGES])
    );
  end

  // Selects are registered so they line up with the ID/EX register contents.
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      fw_sel <= '0;
    end else begin
      fw_sel <= fw_next;
    end
  end

  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_used_f2[k] && (src_reg_f2[k*REG_BITS +: REG_BITS] == wr_reg_f3)) begin
        src_hit = 1'b1;
      end
    end
    hit = mem_read_f3 && (wr_reg_f3 != REG_BITS'(XZR_IDX)) && src_hit;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  // The RUN-state cycle that detects the hit is itself the first stall cycle.
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    stall      = 1'b0;
    case (state)
      RUN: begin
        stall = hit;
        if (hit && (LOAD_STALL_CYCLES > 1)) begin
          state_next = STALL;
          dcnt_next  = DCNT_BITS'(LOAD_STALL_CYCLES - 1);
        end
      end
      STALL: begin
        stall = 1'b1;
        if (dcnt == DCNT_BITS'(1)) begin
          state_next = RUN;
          dcnt_next  = '0;
        end else begin
          dcnt_next = dcnt - DCNT_BITS'(1);
        end
      end
      default: begin
        state_next = RUN;
        dcnt_next  = '0;
      end
    endcase
    if (flush) begin
      state_next = RUN;
      dcnt_next  = '0;
    end
    if (!reset_n) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: three instances (defaults, 3-cycle
// load stall, 4-bit counter) share one stimulus stream.
module tb_fwd_hazard_unit;
  import mips_pipe_pkg::*;

  localparam int RB = 5;

  localparam int K_FW      = 0;
  localparam int K_ST      = 1;
  localparam int K_CNT     = 2;
  localparam int K_ST3     = 3;
  localparam int K_CNT_SAT = 4;
  localparam int K_FW_SAT  = 5;
  localparam int K_ST_SAT  = 6;
  localparam int K_FW3     = 7;
  localparam int K_CNT3    = 8;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [31:0] exp;
  } sb_entry_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [1:0]    wr_en_stg;
  logic [2*RB-1:0] wr_reg_stg;
  logic [2*RB-1:0] src_reg_f3;
  logic [2*RB-1:0] src_reg_f2;
  logic [1:0]    src_used_f2;
  logic          mem_read_f3;
  logic [RB-1:0] wr_reg_f3;

  logic [3:0]  fw_sel_d, fw_sel_3, fw_sel_s;
  logic        stall_d, stall_3, stall_s;
  logic [15:0] stall_cycles_d, stall_cycles_3;
  logic [3:0]  stall_cycles_s;

  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  sb_entry_t sb_q[$];

  fwd_hazard_unit dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .wr_en_stg(wr_en_stg),
    .wr_reg_stg(wr_reg_stg), .src_reg_f3(src_reg_f3), .src_reg_f2(src_reg_f2),
    .src_used_f2(src_used_f2), .mem_read_f3(mem_read_f3), .wr_reg_f3(wr_reg_f3),
    .fw_sel(fw_sel_d), .stall(stall_d), .stall_cycles(stall_cycles_d)
  );

  fwd_hazard_unit #(.LOAD_STALL_CYCLES(3)) dut_ls3 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .wr_en_stg(wr_en_stg),
    .wr_reg_stg(wr_reg_stg), .src_reg_f3(src_reg_f3), .src_reg_f2(src_reg_f2),
    .src_used_f2(src_used_f2), .mem_read_f3(mem_read_f3), .wr_reg_f3(wr_reg_f3),
    .fw_sel(fw_sel_3), .stall(stall_3), .stall_cycles(stall_cycles_3)
  );

  fwd_hazard_unit #(.CNT_BITS(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .flush(flush), .wr_en_stg(wr_en_stg),
    .wr_reg_stg(wr_reg_stg), .src_reg_f3(src_reg_f3), .src_reg_f2(src_reg_f2),
    .src_used_f2(src_used_f2), .mem_read_f3(mem_read_f3), .wr_reg_f3(wr_reg_f3),
    .fw_sel(fw_sel_s), .stall(stall_s), .stall_cycles(stall_cycles_s)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] actualOf(input int kind);
    case (kind)
      K_FW:      return 32'(fw_sel_d);
      K_ST:      return 32'(stall_d);
      K_CNT:     return 32'(stall_cycles_d);
      K_ST3:     return 32'(stall_3);
      K_CNT_SAT: return 32'(stall_cycles_s);
      K_FW_SAT:  return 32'(fw_sel_s);
      K_ST_SAT:  return 32'(stall_s);
      K_FW3:     return 32'(fw_sel_3);
      K_CNT3:    return 32'(stall_cycles_3);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectOut(input int offset, input string name, input int kind, input logic [31:0] val);
    sb_entry_t e;
    e.cyc  = cyc + offset;
    e.name = name;
    e.kind = kind;
    e.exp  = val;
    sb_q.push_back(e);
  endtask

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(
    input logic rst_i, input logic flush_i, input logic [1:0] en_i,
    input logic [RB-1:0] stg1_i, input logic [RB-1:0] stg0_i,
    input logic [RB-1:0] a3_i, input logic [RB-1:0] b3_i,
    input logic [RB-1:0] a2_i, input logic [RB-1:0] b2_i,
    input logic [1:0] used_i, input logic mr_i, input logic [RB-1:0] wf3_i);
    logic [2*RB-1:0] f3, f2;
    @(posedge clock);
    #1;
    f3 = '0;
    f2 = '0;
    f3[SRC_A*RB +: RB] = a3_i;
    f3[SRC_B*RB +: RB] = b3_i;
    f2[SRC_A*RB +: RB] = a2_i;
    f2[SRC_B*RB +: RB] = b2_i;
    reset_n     = rst_i;
    flush       = flush_i;
    wr_en_stg   = en_i;
    wr_reg_stg  = {stg1_i, stg0_i};
    src_reg_f3  = f3;
    src_reg_f2  = f2;
    src_used_f2 = used_i;
    mem_read_f3 = mr_i;
    wr_reg_f3   = wf3_i;
  endtask

  task automatic idle(input logic flush_i);
    applyStimulus(1, flush_i, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Load-use hit on operand B (r7 loaded, r7 read) for every instance.
  task automatic hitB(input logic flush_i);
    applyStimulus(1, flush_i, 2'b00, 0, 0, 0, 0, 2, 7, 2'b10, 1, 7);
  endtask

  always @(negedge clock) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        checkOutput(sb_q[i].name, actualOf(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s never compared (due cycle %0d)", sb_q[i].name, sb_q[i].cyc);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 0; flush = 0; wr_en_stg = 0; wr_reg_stg = 0; src_reg_f3 = 0;
    src_reg_f2 = 0; src_used_f2 = 0; mem_read_f3 = 0; wr_reg_f3 = 0;

    // Reset, with a hazard presented during the second reset cycle
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    expectOut(0, "rst_stall_first", K_ST, 0);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 2, 7, 2'b10, 1, 7);
    expectOut(0, "rst_stall_hazard", K_ST, 0);
    expectOut(0, "rst_stall_hazard_ls3", K_ST3, 0);
    expectOut(0, "rst_fw_sel", K_FW, 0);
    expectOut(0, "rst_stall_cycles", K_CNT, 0);
    expectOut(0, "rst_stall_cycles_ls3", K_CNT3, 0);
    idle(0);
    expectOut(0, "rst_release_stall", K_ST, 0);

    // Forwarding patterns; fw_sel = {B slice, A slice}
    applyStimulus(1, 0, 2'b11, 8, 8, 8, 9, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_nearest", K_FW, 4'b0010);
    expectOut(1, "fwd_nearest_ls3", K_FW3, 4'b0010);
    applyStimulus(1, 0, 2'b01, 5, 3, 3, 3, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_same_operand", K_FW, 4'b0101);
    applyStimulus(1, 0, 2'b00, 5, 3, 3, 3, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_no_stale", K_FW, 4'b0000);
    applyStimulus(1, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_xzr", K_FW, 4'b0000);
    applyStimulus(1, 0, 2'b11, 10, 11, 11, 10, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_split", K_FW, 4'b1001);
    applyStimulus(1, 0, 2'b10, 6, 6, 6, 6, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_stage1_only", K_FW, 4'b1010);
    applyStimulus(1, 1, 2'b11, 12, 12, 12, 12, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_flush", K_FW, 4'b0000);
    applyStimulus(1, 0, 2'b11, 12, 12, 12, 12, 0, 0, 2'b00, 0, 0);
    expectOut(1, "fwd_after_flush", K_FW, 4'b1010);
    idle(0);

    // Single-cycle load-use stall on the default instance
    hitB(0);
    expectOut(0, "lu_stall", K_ST, 1);
    expectOut(0, "lu_cnt_before", K_CNT, 0);
    expectOut(1, "lu_cnt_after", K_CNT, 1);
    idle(0);
    expectOut(0, "lu_one_cycle", K_ST, 0);
    idle(0); idle(0); idle(0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 2, 7, 2'b01, 1, 7);
    expectOut(0, "lu_b_unused", K_ST, 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 7, 0, 2'b01, 1, 7);
    expectOut(0, "lu_a_used", K_ST, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0);
    expectOut(0, "lu_xzr", K_ST, 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 7, 7, 2'b11, 0, 7);
    expectOut(0, "lu_no_load", K_ST, 0);
    idle(0); idle(0); idle(0);

    // Three-cycle stall from a one-cycle hit pulse
    hitB(0);
    expectOut(0, "ls3_c1", K_ST3, 1);
    expectOut(1, "ls3_c2", K_ST3, 1);
    expectOut(2, "ls3_c3", K_ST3, 1);
    expectOut(3, "ls3_end", K_ST3, 0);
    idle(0); idle(0); idle(0); idle(0);

    // Flush in the second stall cycle returns the FSM to RUN
    hitB(0);
    expectOut(0, "fl_c1", K_ST3, 1);
    idle(1);
    expectOut(0, "fl_c2", K_ST3, 1);
    expectOut(1, "fl_drop", K_ST3, 0);
    idle(0); idle(0);
    expectOut(0, "fl_run", K_ST3, 0);

    // Flush coinciding with a hit: stall follows hit, FSM stays in RUN
    hitB(1);
    expectOut(0, "flush_hit_stall", K_ST, 1);
    expectOut(0, "flush_hit_stall_ls3", K_ST3, 1);
    expectOut(1, "flush_hit_no_fsm", K_ST3, 0);
    idle(0); idle(0);

    // Hold a hazard for 20 cycles with forwarding active, then reset
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 2'b11, 8, 8, 8, 9, 2, 7, 2'b10, 1, 7);
      if (i == 0) expectOut(0, "sat_stall", K_ST_SAT, 1);
    end
    expectOut(1, "sat_count", K_CNT_SAT, 15);
    expectOut(1, "sat_fw_sel", K_FW_SAT, 4'b0010);
    applyStimulus(0, 0, 2'b11, 8, 8, 8, 9, 2, 7, 2'b10, 1, 7);
    expectOut(0, "sat_rst_stall", K_ST_SAT, 0);
    expectOut(1, "sat_rst_count", K_CNT_SAT, 0);
    expectOut(1, "sat_rst_fw_sel", K_FW_SAT, 0);
    idle(0); idle(0); idle(0);

    @(negedge clock);
    @(negedge clock);
    while (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s left in scoreboard (due cycle %0d)", sb_q[0].name, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
